// File: rtl/zbus_master_pkg.sv
// ============================================================================
// zbus_master_pkg : shared types and constants for the ZX-bus initiator
// Revision        : 1.0
// ============================================================================
`default_nettype none

package zbus_master_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T1   = 3'd1,
      T2   = 3'd2,
      TWA  = 3'd3,
      TW   = 3'd4,
      T3   = 3'd5,
      FIN  = 3'd6
   } state_e;

   // Strobe vectors are ordered {mreq_n, iorq_n, rd_n, wr_n}
   localparam logic [3:0] STROBE_IDLE = 4'b1111;
   localparam logic [7:0] RDATA_ABORT = 8'hFF;

   function automatic logic [3:0] strobe_active(input logic io, input logic wr);
      return {io, ~io, wr, ~wr};
   endfunction

endpackage

`default_nettype wire

// File: rtl/zbus_master_if.sv
// ============================================================================
// zbus_master_if : request/done handshake between a requester and zbus_master
// Revision       : 1.0
// ============================================================================
`default_nettype none

interface zbus_master_if;
   logic        req;
   logic        req_rdy;
   logic        req_io;
   logic        req_wr;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        done;
   logic        err;
   logic [7:0]  rdata;

   modport master (
      output req, req_io, req_wr, req_addr, req_wdata,
      input  req_rdy, done, err, rdata
   );

   modport slave (
      input  req, req_io, req_wr, req_addr, req_wdata,
      output req_rdy, done, err, rdata
   );
endinterface

`default_nettype wire

// File: rtl/zbus_tstate_timer.sv
// ============================================================================
// zbus_tstate_timer : fclk-per-T-state prescaler, cleared when a request is accepted
// Revision          : 1.0
// ============================================================================
`default_nettype none

module zbus_tstate_timer #(
   parameter int T_DIV = 2
) (
   input  logic fclk,
   input  logic rst_n,
   input  logic clr,
   output logic t_last
);

   localparam int CW = $clog2(T_DIV);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign t_last = (cnt_q == CW'(T_DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CW'(1);
      if (clr || t_last) cnt_d = '0;
   end

   always_ff @(posedge fclk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

`default_nettype wire

// File: rtl/zbus_master.sv
// ============================================================================
// zbus_master : Z80-style memory/I/O cycle generator driven by a request/done handshake
// Revision    : 1.0
// ============================================================================
`default_nettype none

module zbus_master
   import zbus_master_pkg::*;
#(
   parameter int T_DIV    = 2,
   parameter int MAX_WAIT = 255
) (
   input  logic                fclk,
   input  logic                rst_n,
   zbus_master_if.slave        bus,
   output logic [15:0]         za,
   inout  wire  [7:0]          zd,
   output logic                zmreq_n,
   output logic                ziorq_n,
   output logic                zrd_n,
   output logic                zwr_n,
   input  logic                zwait_n
);

   localparam int WCW = $clog2(MAX_WAIT + 2);

   state_e           state_q, state_d;
   logic             io_q, io_d;
   logic             wr_q, wr_d;
   logic [15:0]      za_q, za_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             abort_q, abort_d;
   logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;

   logic             t_last;
   logic             accept;
   logic             timeout;
   logic             abort_now;
   logic             zd_oe;
   logic [3:0]       strobes;

   assign accept    = bus.req && (state_q == IDLE);
   assign timeout   = (wait_cnt_q >= WCW'(MAX_WAIT));
   assign abort_now = (state_q == TW) && t_last && !zwait_n && timeout;

   zbus_tstate_timer #(.T_DIV(T_DIV)) u_timer (
      .fclk   (fclk),
      .rst_n  (rst_n),
      .clr    (accept),
      .t_last (t_last)
   );

   always_ff @(posedge fclk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = T1;
         T1:      if (t_last) state_d = T2;
         T2:      if (t_last) state_d = io_q ? TWA : (zwait_n ? T3 : TW);
         TWA:     if (t_last) state_d = zwait_n ? T3 : TW;
         TW:      if (t_last) state_d = zwait_n ? T3 : (timeout ? FIN : TW);
         T3:      if (t_last) state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      strobes = STROBE_IDLE;
      if (state_q inside {T2, TWA, TW, T3}) strobes = strobe_active(io_q, wr_q);
      zd_oe       = wr_q && (state_q != IDLE);
      bus.req_rdy = (state_q == IDLE);
      bus.done    = (state_q == FIN);
      bus.err     = (state_q == FIN) && abort_q;
   end

   assign {zmreq_n, ziorq_n, zrd_n, zwr_n} = strobes;
   assign za        = za_q;
   assign zd        = zd_oe ? wdata_q : 8'hzz;
   assign bus.rdata = rdata_q;

   // Wait counter holds the number of TW states entered so far in this cycle
   always_comb begin
      io_d       = io_q;
      wr_d       = wr_q;
      za_d       = za_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      abort_d    = abort_q;
      wait_cnt_d = wait_cnt_q;
      if (accept) begin
         io_d       = bus.req_io;
         wr_d       = bus.req_wr;
         za_d       = bus.req_addr;
         wdata_d    = bus.req_wdata;
         abort_d    = 1'b0;
         wait_cnt_d = '0;
      end else if (t_last && !zwait_n) begin
         if ((state_q == T2 && !io_q) || state_q == TWA) wait_cnt_d = WCW'(1);
         else if (state_q == TW && !timeout)             wait_cnt_d = wait_cnt_q + WCW'(1);
      end
      if (state_q == T3 && t_last && !wr_q) rdata_d = zd;
      if (abort_now) begin
         abort_d = 1'b1;
         rdata_d = RDATA_ABORT;
      end
   end

   always_ff @(posedge fclk) begin
      if (!rst_n) begin
         io_q       <= 1'b0;
         wr_q       <= 1'b0;
         za_q       <= '0;
         wdata_q    <= '0;
         rdata_q    <= RDATA_ABORT;
         abort_q    <= 1'b0;
         wait_cnt_q <= '0;
      end else begin
         io_q       <= io_d;
         wr_q       <= wr_d;
         za_q       <= za_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         abort_q    <= abort_d;
         wait_cnt_q <= wait_cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_zbus_master.sv
// ============================================================================
// tb_zbus_master : scoreboard bench with a bus responder and a cycle-level reference model
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_zbus_master;

   localparam int TD = 2;
   localparam int MW = 4;

   typedef struct {
      bit          io;
      bit          wr;
      logic [15:0] addr;
      logic [7:0]  wdata;
      int          nw;
      int          acc;
   } txn_t;

   logic        fclk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] za;
   wire  [7:0]  zd;
   logic        zmreq_n, ziorq_n, zrd_n, zwr_n;
   logic        zwait_n = 1'b1;
   logic        tb_oe = 1'b0;
   logic [7:0]  tb_val = 8'h00;

   int   cyc = 0;
   int   sc = 0;
   int   last_done = -100;
   int   checks = 0;
   int   failures = 0;
   txn_t exp_q[$];

   logic [7:0] ref_mem  [logic [16:0]];
   logic [7:0] resp_mem [logic [16:0]];

   zbus_master_if bus ();

   zbus_master #(.T_DIV(TD), .MAX_WAIT(MW)) dut (
      .fclk    (fclk),
      .rst_n   (rst_n),
      .bus     (bus),
      .za      (za),
      .zd      (zd),
      .zmreq_n (zmreq_n),
      .ziorq_n (ziorq_n),
      .zrd_n   (zrd_n),
      .zwr_n   (zwr_n),
      .zwait_n (zwait_n)
   );

   assign zd = tb_oe ? tb_val : 8'hzz;

   always #5 fclk = ~fclk;
   always @(posedge fclk) cyc <= cyc + 1;

   function automatic logic [7:0] init_val(input logic [16:0] k);
      return k[7:0] ^ k[15:8] ^ {7'd0, k[16]} ^ 8'h1A;
   endfunction

   function automatic logic [7:0] ref_rd(input logic [16:0] k);
      return ref_mem.exists(k) ? ref_mem[k] : init_val(k);
   endfunction

   function automatic logic [7:0] resp_rd(input logic [16:0] k);
      return resp_mem.exists(k) ? resp_mem[k] : init_val(k);
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endfunction

   // Responder: holds WAIT for a programmed number of samples, returns read data, commits writes
   always @(posedge fclk) sc <= (!zmreq_n || !ziorq_n) ? sc + 1 : 0;

   always @(negedge fclk) begin : responder
      int          lim;
      logic [16:0] k;
      static bit          pend = 0;
      static bit          pend_ok = 0;
      static logic [16:0] pend_key = '0;
      static logic [7:0]  pend_dat = '0;
      k   = {!ziorq_n, za};
      lim = 0;
      if (exp_q.size() > 0) lim = (!ziorq_n ? exp_q[0].nw + 1 : exp_q[0].nw) * TD;
      zwait_n = !((!zmreq_n || !ziorq_n) && sc < lim);
      tb_oe   = !zrd_n;
      tb_val  = resp_rd(k);
      if (!zwr_n) begin
         pend     = 1;
         pend_key = k;
         pend_dat = zd;
         if (zwait_n) pend_ok = 1;
      end else if (pend) begin
         if (pend_ok && rst_n) resp_mem[pend_key] = pend_dat;
         pend    = 0;
         pend_ok = 0;
      end
   end

   // Monitor: every cycle of an in-flight transaction is checked against its expected timeline
   always @(negedge fclk) begin : monitor
      txn_t        e;
      int          r, s, lat;
      bit          ab;
      logic [3:0]  act, strb;
      logic [16:0] key;
      if (rst_n) begin
         strb = {zmreq_n, ziorq_n, zrd_n, zwr_n};
         if (exp_q.size() > 0 && exp_q[0].acc < cyc) begin
            e   = exp_q[0];
            r   = cyc - e.acc;
            ab  = (e.nw > MW);
            s   = ab ? ((e.io ? 2 : 1) + MW) * TD : ((e.io ? 3 : 2) + e.nw) * TD;
            lat = TD + s + 1;
            act = {e.io, !e.io, e.wr, !e.wr};
            key = {e.io, e.addr};
            chk("strobes", {28'd0, strb}, {28'd0, (r > TD && r <= TD + s) ? act : 4'hF});
            chk("za", {16'd0, za}, {16'd0, e.addr});
            chk("zd_drive", {31'd0, dut.zd_oe}, {31'd0, e.wr});
            if (e.wr) chk("zd_wdata", {24'd0, zd}, {24'd0, e.wdata});
            chk("done", {31'd0, bus.done}, {31'd0, r == lat});
            if (r >= lat) begin
               chk("err", {31'd0, bus.err}, {31'd0, ab});
               if (ab)        chk("rdata_abort", {24'd0, bus.rdata}, 32'hFF);
               else if (!e.wr) chk("rdata", {24'd0, bus.rdata}, {24'd0, ref_rd(key)});
               if (!ab && e.wr) ref_mem[key] = e.wdata;
               last_done = cyc;
               void'(exp_q.pop_front());
            end
         end else begin
            chk("idle_done", {31'd0, bus.done}, 32'd0);
            chk("idle_strobes", {28'd0, strb}, 32'hF);
            chk("idle_zd", {31'd0, dut.zd_oe}, 32'd0);
         end
      end
   end

   task automatic issue(input bit io, input bit wr, input logic [15:0] a, input logic [7:0] d,
                        input int nw, input bit hold, input bit b2b);
      txn_t e;
      int   t = 0;
      bus.req       = 1'b1;
      bus.req_io    = io;
      bus.req_wr    = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      while (!bus.req_rdy && t < 400) begin
         @(negedge fclk);
         t++;
      end
      if (!bus.req_rdy) begin
         chk("accept_timeout", 32'd0, 32'd1);
      end else begin
         if (b2b) chk("b2b_gap", cyc, last_done + 1);
         e = '{io: io, wr: wr, addr: a, wdata: d, nw: nw, acc: cyc};
         exp_q.push_back(e);
      end
      @(negedge fclk);
      if (!hold) bus.req = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() > 0 && t < 400) begin
         @(negedge fclk);
         t++;
      end
      chk("drain_timeout", exp_q.size(), 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int nw, sel;
      bit io, wr, hold, prev_hold;
      logic [15:0] bases [4];
      bases = '{16'h4000, 16'h80AB, 16'h00FE, 16'hFFFC};
      bus.req = 0; bus.req_io = 0; bus.req_wr = 0; bus.req_addr = '0; bus.req_wdata = '0;
      repeat (3) @(negedge fclk);
      chk("rst_req_rdy", {31'd0, bus.req_rdy}, 32'd1);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_err", {31'd0, bus.err}, 32'd0);
      chk("rst_rdata", {24'd0, bus.rdata}, 32'hFF);
      chk("rst_za", {16'd0, za}, 32'd0);
      chk("rst_strobes", {28'd0, zmreq_n, ziorq_n, zrd_n, zwr_n}, 32'hF);
      chk("rst_zd", {31'd0, dut.zd_oe}, 32'd0);
      rst_n = 1'b1;
      @(negedge fclk);

      issue(0, 0, 16'h4000, 8'h00, 0, 0, 0);
      drain();
      chk("tp_mem_read_data", {24'd0, bus.rdata}, 32'h5A);
      issue(1, 1, 16'h80AB, 8'hC3, 0, 0, 0);
      drain();
      issue(0, 0, 16'h1234, 8'h00, 3, 0, 0);
      drain();
      issue(1, 0, 16'h00FE, 8'h00, 100, 0, 0);
      drain();
      chk("tp_abort_rdata", {24'd0, bus.rdata}, 32'hFF);

      // Reset in the first T3 cycle of a memory write: must drop the write and the done
      issue(0, 1, 16'h2222, 8'h77, 0, 0, 0);
      repeat (4) @(negedge fclk);
      rst_n = 1'b0;
      @(negedge fclk);
      chk("midrst_strobes", {28'd0, zmreq_n, ziorq_n, zrd_n, zwr_n}, 32'hF);
      chk("midrst_zd", {31'd0, dut.zd_oe}, 32'd0);
      chk("midrst_done", {31'd0, bus.done}, 32'd0);
      chk("midrst_req_rdy", {31'd0, bus.req_rdy}, 32'd1);
      exp_q.delete();
      @(negedge fclk);
      rst_n = 1'b1;
      @(negedge fclk);
      issue(0, 0, 16'h2222, 8'h00, 0, 0, 0);
      drain();

      issue(0, 1, 16'h4001, 8'h11, 0, 1, 0);
      issue(0, 0, 16'h4001, 8'h00, 0, 0, 1);
      drain();

      prev_hold = 0;
      for (int i = 0; i < 80; i++) begin
         io   = $urandom_range(0, 1) == 1;
         wr   = $urandom_range(0, 1) == 1;
         hold = $urandom_range(0, 2) == 0;
         sel  = $urandom_range(0, 9);
         if (sel < 6)       nw = 0;
         else if (sel < 8)  nw = $urandom_range(1, 3);
         else if (sel == 8) nw = MW;
         else               nw = MW + 1 + $urandom_range(0, 3);
         issue(io, wr, bases[$urandom_range(0, 3)] + 16'($urandom_range(0, 3)),
               8'($urandom), nw, hold, prev_hold);
         prev_hold = hold;
      end
      bus.req = 1'b0;
      drain();
      repeat (3) @(negedge fclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
